// File: rtl/rresp_scheduler.sv
// Read-response scheduler: collects per-RID completions, grants round-robin, issues one
// response per grant and then pulses clear so the error buffer drops that RID's bit.
module rresp_scheduler #(
    parameter logic [1:0] OKAY_RESP = 2'b00,
    parameter logic [1:0] ERR_RESP  = 2'b10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] done,
    input  logic [3:0] error,
    input  logic       rready,
    output logic       rvalid,
    output logic [1:0] rid,
    output logic [1:0] rresp,
    output logic       clear,
    output logic [1:0] clear_rid
);

    typedef enum logic [1:0] {StIdle, StResp, StClear} state_e;

    state_e     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] rid_q, rid_d;
    logic [1:0] rresp_q, rresp_d;
    logic [3:0] clr_mask;

    logic       grant_valid;
    logic [1:0] grant_rid;
    logic [1:0] scan_idx;

    // Scan from the farthest offset down so the nearest pending RID to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_rid   = ptr_q;
        scan_idx    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (pending_q[scan_idx]) begin
                grant_valid = 1'b1;
                grant_rid   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        clr_mask = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    rid_d   = grant_rid;
                    rresp_d = error[grant_rid] ? ERR_RESP : OKAY_RESP;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rready) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                clr_mask = 4'b0001 << rid_q;
                ptr_d    = rid_q + 2'd1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A completion arriving alongside its own clear must survive.
        pending_d = (pending_q & ~clr_mask) | done;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            pending_q <= 4'b0000;
            ptr_q     <= 2'd0;
            rid_q     <= 2'd0;
            rresp_q   <= OKAY_RESP;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
        end
    end

    assign rvalid    = (state_q == StResp);
    assign clear     = (state_q == StClear);
    assign rid       = rid_q;
    assign rresp     = rresp_q;
    assign clear_rid = rid_q;

endmodule

// File: tb/tb_rresp_scheduler.sv
// Testbench for rresp_scheduler: directed scenarios plus randomized traffic compared against
// a transaction-level model of the pending set, round-robin pointer and response phase.
module tb_rresp_scheduler;

    logic       clk;
    logic       n_rst;
    logic [3:0] done;
    logic [3:0] error;
    logic       rready;
    logic       rvalid;
    logic [1:0] rid;
    logic [1:0] rresp;
    logic       clear;
    logic [1:0] clear_rid;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting for work, 1 = response offered, 2 = clear pulse.
    int         m_phase;
    logic [3:0] m_pending;
    logic [1:0] m_ptr;
    logic [1:0] m_rid;
    logic [1:0] m_rresp;

    rresp_scheduler dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .done      (done),
        .error     (error),
        .rready    (rready),
        .rvalid    (rvalid),
        .rid       (rid),
        .rresp     (rresp),
        .clear     (clear),
        .clear_rid (clear_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] start);
        logic [1:0] r;
        r = start;
        for (int k = 3; k >= 0; k--) begin
            if (p[(int'(start) + k) % 4]) r = 2'((int'(start) + k) % 4);
        end
        return r;
    endfunction

    // Apply one cycle of inputs, advance one edge, update the model, sample #1 later.
    task automatic step(input logic [3:0] d, input logic [3:0] e, input logic r);
        logic [1:0] g;
        done   = d;
        error  = e;
        rready = r;
        @(posedge clk);
        if (!n_rst) begin
            m_phase = 0; m_pending = 4'b0; m_ptr = 2'd0; m_rid = 2'd0; m_rresp = 2'b00;
        end else begin
            case (m_phase)
                0: if (m_pending != 4'b0) begin
                    g = rr_pick(m_pending, m_ptr);
                    m_rid = g;
                    m_rresp = e[g] ? 2'b10 : 2'b00;
                    m_phase = 1;
                end
                1: if (r) m_phase = 2;
                default: begin
                    m_pending[m_rid] = 1'b0;
                    m_ptr = m_rid + 2'd1;
                    m_phase = 0;
                end
            endcase
            m_pending = m_pending | d;
        end
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rid !== 2'd0) begin errors++; $display("FAIL reset_rid: got %0d expected 0", rid); end
        checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b expected 00", rresp); end
        checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", clear); end
        checks++; if (clear_rid !== 2'd0) begin errors++; $display("FAIL reset_clear_rid: got %0d expected 0", clear_rid); end
        checks++; if (dut.pending_q !== 4'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0000", dut.pending_q); end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
        n_rst = 1'b1;
    endtask

    task automatic test_single();
        step(4'b0100, 4'b0100, 1'b1);
        checks++; if (dut.pending_q !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b expected 0100", dut.pending_q); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", rvalid); end
        step(4'b0000, 4'b0100, 1'b1);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b expected 1", rvalid); end
        checks++; if (rid !== 2'd2) begin errors++; $display("FAIL single_rid: got %0d expected 2", rid); end
        checks++; if (rresp !== 2'b10) begin errors++; $display("FAIL single_rresp: got %b expected 10", rresp); end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (clear !== 1'b1 || clear_rid !== 2'd2) begin
            errors++; $display("FAIL single_clear: got %b/%0d expected 1/2", clear, clear_rid); end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (clear !== 1'b0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL single_idle: got clear %b rvalid %b expected 0/0", clear, rvalid); end
        checks++; if (dut.pending_q !== 4'b0) begin errors++; $display("FAIL single_pending_clr: got %b expected 0000", dut.pending_q); end
    endtask

    task automatic test_round_robin();
        test_reset();
        step(4'b1111, 4'b0000, 1'b1);
        for (int t = 2; t <= 13; t++) begin
            logic exp_v;
            step(4'b0000, 4'b0000, 1'b1);
            exp_v = (t <= 11) && ((t - 2) % 3 == 0);
            checks++; if (rvalid !== exp_v) begin
                errors++; $display("FAIL rr_rvalid_t%0d: got %b expected %b", t, rvalid, exp_v); end
            if (exp_v) begin
                checks++; if (rid !== 2'((t - 2) / 3) || rresp !== 2'b00) begin
                    errors++; $display("FAIL rr_rid_t%0d: got %0d/%b expected %0d/00", t, rid, rresp, (t - 2) / 3); end
            end
        end
        checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL rr_ptr: got %0d expected 0", dut.ptr_q); end
    endtask

    task automatic test_backpressure();
        step(4'b0010, 4'b0010, 1'b0);
        step(4'b0000, 4'b0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, (i % 2 == 0) ? 4'b0000 : 4'b0010, 1'b0);
            checks++; if (rvalid !== 1'b1 || rid !== 2'd1 || rresp !== 2'b10 || clear !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: got v%b id%0d resp%b clr%b expected v1 id1 resp10 clr0",
                                   i, rvalid, rid, rresp, clear); end
        end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (clear !== 1'b1 || clear_rid !== 2'd1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL bp_clear: got clr%b id%0d v%b expected 1/1/0", clear, clear_rid, rvalid); end
        step(4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_set_wins();
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (rvalid !== 1'b1 || rid !== 2'd1) begin
            errors++; $display("FAIL sw_first: got v%b id%0d expected v1 id1", rvalid, rid); end
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        checks++; if (dut.pending_q[1] !== 1'b1) begin
            errors++; $display("FAIL sw_pending: got %b expected 1", dut.pending_q[1]); end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (rvalid !== 1'b1 || rid !== 2'd1) begin
            errors++; $display("FAIL sw_second: got v%b id%0d expected v1 id1", rvalid, rid); end
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (dut.pending_q !== 4'b0) begin errors++; $display("FAIL sw_drain: got %b expected 0000", dut.pending_q); end
    endtask

    task automatic test_wrap();
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL wrap_ptr: got %0d expected 3", dut.ptr_q); end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (rvalid !== 1'b1 || rid !== 2'd0) begin
            errors++; $display("FAIL wrap_first: got v%b id%0d expected v1 id0", rvalid, rid); end
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (rvalid !== 1'b1 || rid !== 2'd1) begin
            errors++; $display("FAIL wrap_second: got v%b id%0d expected v1 id1", rvalid, rid); end
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic test_reset_mid_resp();
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rmr_pre: got %b expected 1", rvalid); end
        n_rst = 1'b0;
        step(4'b0001, 4'b0000, 1'b1);
        n_rst = 1'b1;
        checks++; if (rvalid !== 1'b0 || clear !== 1'b0 || dut.pending_q !== 4'b0) begin
            errors++; $display("FAIL rmr_reset: got v%b clr%b pend%b expected 0/0/0000", rvalid, clear, dut.pending_q); end
        step(4'b0000, 4'b0000, 1'b1);
        checks++; if (clear !== 1'b0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rmr_after: got clr%b v%b expected 0/0", clear, rvalid); end
    endtask

    task automatic test_random();
        test_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] d;
            n_rst = ($urandom_range(0, 79) != 0);
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(d, 4'($urandom), ($urandom_range(0, 2) != 0));
            checks++; if (rvalid !== (m_phase == 1)) begin
                errors++; $display("FAIL rnd_rvalid_c%0d: got %b expected %b", c, rvalid, m_phase == 1); end
            checks++; if (clear !== (m_phase == 2)) begin
                errors++; $display("FAIL rnd_clear_c%0d: got %b expected %b", c, clear, m_phase == 2); end
            checks++; if (rid !== m_rid || clear_rid !== m_rid) begin
                errors++; $display("FAIL rnd_rid_c%0d: got %0d/%0d expected %0d", c, rid, clear_rid, m_rid); end
            checks++; if (rresp !== m_rresp) begin
                errors++; $display("FAIL rnd_rresp_c%0d: got %b expected %b", c, rresp, m_rresp); end
            checks++; if (dut.pending_q !== m_pending) begin
                errors++; $display("FAIL rnd_pending_c%0d: got %b expected %b", c, dut.pending_q, m_pending); end
        end
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst  = 1'b0;
        done   = 4'b0;
        error  = 4'b0;
        rready = 1'b0;
        m_phase = 0; m_pending = 4'b0; m_ptr = 2'd0; m_rid = 2'd0; m_rresp = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_set_wins();
        test_wrap();
        test_reset_mid_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rresp_scheduler.md
# rresp_scheduler

Consumer side of the per-RID error bit buffer. It collects read-completion pulses for RIDs 0–3 and arbitrates among pending RIDs round-robin. For each winner it issues one read response on a valid/ready channel, with RRESP taken from that RID's error bit. After the handshake it pulses `clear` with the RID so the error buffer drops that bit.

## Interface
Parameters:
- `OKAY_RESP`, default 2'b00: RRESP value when the RID's error bit is 0.
- `ERR_RESP`, default 2'b10: RRESP value when the RID's error bit is 1 (SLVERR).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `n_rst`, input, 1: reset, synchronous and active-low.
- `done`, input, 4: per-RID one-cycle pulse marking a read complete. Multiple bits may be high in one cycle.
- `error`, input, 4: per-RID error bits from the error buffer.
- `rready`, input, 1: downstream accepts the response.
- `rvalid`, output, 1: response valid.
- `rid`, output, 2: RID of the current response.
- `rresp`, output, 2: response code.
- `clear`, output, 1: one-cycle pulse to the error buffer.
- `clear_rid`, output, 2: RID being cleared. It equals `rid` while `clear` is high.

## Operation
- `pending[3:0]` register:
  - A bit is set on `done[i]`.
  - A bit is cleared in the CLEAR state for the granted RID.
  - If `done[i]` and the clear of RID i occur in the same cycle, set wins and the bit stays 1.
- `ptr[1:0]` is the round-robin start point. After each grant it becomes granted RID + 1, modulo 4 (3 wraps to 0).
- FSM states: IDLE, RESP, CLEAR.
  - IDLE: if `pending` is nonzero, pick the first set bit scanning from `ptr` upward with wrap. On that edge, latch the RID into `rid` and latch `rresp` (`ERR_RESP` if `error[rid]` is 1, else `OKAY_RESP`), then go to RESP. If nothing is pending, stay in IDLE.
  - RESP: `rvalid`=1. `rid` and `rresp` are held stable and must not change while `rvalid` is high, even if `error` changes. Go to CLEAR on the cycle where `rvalid && rready`; otherwise stay.
  - CLEAR: `clear`=1 and `clear_rid`=`rid` for exactly one cycle. Clear `pending[rid]` (subject to the set-wins rule), update `ptr`, return to IDLE.
- `clear_rid` holds the last granted RID when not in CLEAR.

## Timing
- Reset (`n_rst`=0 at an edge): state=IDLE, `pending`=0, `ptr`=0, `rvalid`=0, `rid`=0, `rresp`=`OKAY_RESP`, `clear`=0, `clear_rid`=0.
  - Reset in RESP or CLEAR drops the response with no `clear` pulse.
  - Reset overrides any `done` pulse in the same cycle.
- Latency, from a `done[i]` pulse in cycle N with the block idle: `pending[i]`=1 in N+1, `rvalid`=1 in N+2.
- The cycle after `rready` is sampled high, `clear`=1. The cycle after that is IDLE again.
- Minimum spacing between responses is 3 cycles (RESP, CLEAR, IDLE), so back-to-back grants have `rvalid` high in cycles K and K+3.
- `error` is sampled only on the IDLE→RESP edge.
- The error buffer ignores `err` for one cycle after a clear. The `clear` pulse is exactly one cycle long and never repeats for the same grant.
- `done` pulses that arrive in RESP or CLEAR are captured in `pending`; none are lost.
- Outputs `rvalid`, `rid`, `rresp`, `clear` and `clear_rid` are registered or decoded from state only. None is combinational from `rready` or `done`.

## Test plan
- Reset, then `done`=4'b0100 with `error`=4'b0100 and `rready`=1:
  - `rvalid` high 2 cycles after `done` with `rid`=2 and `rresp`=2'b10.
  - Next cycle `clear`=1 with `clear_rid`=2.
  - `pending` then reads 0.
- Round-robin: `done`=4'b1111 in one cycle, `error`=0, `rready`=1 → responses in RID order 0, 1, 2, 3 with `rvalid` at K, K+3, K+6, K+9, all `rresp`=2'b00. After RID 3, `ptr`=0.
- Backpressure: hold `rready`=0 for 5 cycles while `error[rid]` toggles → `rvalid`, `rid` and `rresp` stay stable throughout, and `clear` stays 0 until the cycle after `rready`=1.
- Set-wins race: `done[1]` pulses in the same cycle as the CLEAR for RID 1 → `pending[1]` stays 1 and a second response for RID 1 is issued.
- Wrap: `ptr`=3 with `pending`=4'b0011 → next grant is RID 0, then RID 1.
- Reset mid-RESP: `n_rst`=0 while `rvalid`=1 → next cycle `rvalid`=0, `pending`=0, no `clear` pulse.
